// File: rtl/crc_rx_check.sv
// crc_rx_check: receive-side CRC-16 checker for the serial link.
// Deserialises a 48-bit frame (32-bit payload then 16-bit CRC, MSB first),
// runs a non-reflected CRC (init 0, no final XOR) over all 48 bits and
// reports pass/fail together with the recovered payload and CRC field.
// Optional feature macro: CRC_ERR_CNT_EN adds a saturating 8-bit count of
// completed frames that failed the CRC check (err_cnt).
module crc_rx_check #(
  parameter int unsigned      DATA_W = 32,
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] payload,
  output logic [CRC_W-1:0]  crc_rx,
  output logic              done,
  output logic              crc_ok,
  output logic              busy,
  output logic              frame_err
`ifdef CRC_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned FRAME_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CRC_W-1:0]   crc_q, crc_d, crc_sh, crc_first;
  logic [FRAME_W-1:0] shreg_q, shreg_d, shreg_sh;
  logic [DATA_W-1:0]  payload_d;
  logic [CRC_W-1:0]   crc_rx_d;
  logic               crc_ok_d;
  logic               done_d;
  logic               busy_d;
  logic               frame_err_d;

  // One LFSR step: shift left, fold in the polynomial when feedback is set.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic             b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // Shared datapath candidates for the current input bit.
  always_comb begin
    shreg_sh  = {shreg_q[FRAME_W-2:0], in_bit};
    crc_sh    = crc_step(crc_q, in_bit);
    crc_first = crc_step('0, in_bit);
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    shreg_d     = shreg_q;
    payload_d   = payload;
    crc_rx_d    = crc_rx;
    crc_ok_d    = crc_ok;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && start) begin
          state_d = ST_PAYLOAD;
          cnt_d   = CNT_W'(1);
          crc_d   = crc_first;
          shreg_d = shreg_sh;
        end
      end

      ST_PAYLOAD, ST_CHECK: begin
        if (in_valid) begin
          if (start) begin
            // Restart mid-frame: drop the partial frame, this bit is bit 1.
            frame_err_d = 1'b1;
            state_d     = ST_PAYLOAD;
            cnt_d       = CNT_W'(1);
            crc_d       = crc_first;
            shreg_d     = shreg_sh;
          end else begin
            shreg_d = shreg_sh;
            crc_d   = crc_sh;
            cnt_d   = cnt_inc;
            if (state_q == ST_PAYLOAD && cnt_inc == CNT_W'(DATA_W)) begin
              state_d = ST_CHECK;
            end
            if (state_q == ST_CHECK && cnt_inc == CNT_W'(FRAME_W)) begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              payload_d = shreg_sh[FRAME_W-1:CRC_W];
              crc_rx_d  = shreg_sh[CRC_W-1:0];
              crc_ok_d  = (crc_sh == '0);
            end
          end
        end
      end

      ST_DONE: begin
        if (in_valid && start) begin
          // Back-to-back frame: first bit lands in the done cycle.
          state_d = ST_PAYLOAD;
          cnt_d   = CNT_W'(1);
          crc_d   = crc_first;
          shreg_d = shreg_sh;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_PAYLOAD) || (state_d == ST_CHECK);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      shreg_q   <= '0;
      payload   <= '0;
      crc_rx    <= '0;
      crc_ok    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      shreg_q   <= shreg_d;
      payload   <= payload_d;
      crc_rx    <= crc_rx_d;
      crc_ok    <= crc_ok_d;
      done      <= done_d;
      busy      <= busy_d;
      frame_err <= frame_err_d;
    end
  end

`ifdef CRC_ERR_CNT_EN
  // Saturating count of completed frames whose CRC check failed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (done_d && !crc_ok_d && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/crc_rx_check.md
# crc_rx_check

- Receive-side CRC-16 checker for the serial link.
- Deserialises one 48-bit frame (32-bit payload followed by 16-bit CRC, MSB first) from the serial bit stream, runs the CRC over all 48 bits, and reports pass/fail with the recovered payload.
- Sits after the de-interleaver/decoder path, at the opposite end of the transmit CRC generator and serialiser.

## Interface
Parameters:
- DATA_W, 32, payload bits per frame
- CRC_W, 16, CRC bits per frame
- POLY, 16'h1021, CRC generator polynomial (x^16 term implicit)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start; must be high in the same cycle as the first valid bit
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data, MSB of payload first, then CRC MSB first
- payload  out  DATA_W  recovered payload; updated only at done
- crc_rx  out  CRC_W  received CRC field; updated only at done
- done  out  1  one-cycle pulse: frame complete
- crc_ok  out  1  valid with done, held until next done
- busy  out  1  frame in progress
- frame_err  out  1  one-cycle pulse: frame aborted by restart

## Operation
- States: IDLE, PAYLOAD, CHECK (CRC field), DONE.
- IDLE:
  - start & in_valid: sample the bit, clear the CRC register, load bit_cnt=1, go to PAYLOAD.
  - in_valid without start: ignore.
- PAYLOAD:
  - Each in_valid shifts in_bit into the shift register and the CRC LFSR, and increments bit_cnt.
  - When bit_cnt reaches DATA_W, go to CHECK.
- CHECK:
  - Same shifting continues.
  - On the valid bit that makes bit_cnt = DATA_W+CRC_W, go to DONE.
- DONE:
  - One cycle. done=1; payload/crc_rx/crc_ok are loaded.
  - Next state is IDLE; if start & in_valid are present in this cycle, go straight to PAYLOAD with bit_cnt=1.
- CRC LFSR:
  - Non-reflected, init 0, no final XOR.
  - fb = crc[CRC_W-1] ^ in_bit; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - The CRC runs over all 48 bits; crc_ok = (remainder == 0).
- in_valid low: no state, counter or CRC change (gaps allowed anywhere in a frame).
- start & in_valid in PAYLOAD or CHECK: frame_err pulses, the current frame is discarded (no done), and a new frame starts with this bit as bit 1.
- start without in_valid: ignored.
- bit_cnt width: clog2(DATA_W+CRC_W+1).
- busy = state is PAYLOAD or CHECK.

## Timing
- Reset values:
  - state=IDLE, bit_cnt=0, CRC reg=0.
  - payload=0, crc_rx=0, done=0, crc_ok=0, busy=0, frame_err=0.
- done rises in the cycle after the edge that samples the 48th valid bit, and is high for exactly 1 cycle.
- payload/crc_rx/crc_ok are stable from done until the next done.
- Back-to-back frames: the next frame's first bit may arrive in the DONE cycle; there is no dead cycle.
- rst_n low mid-frame: all state clears immediately (async), no done, and the partial frame is lost.
- Minimum frame time: 48 valid cycles, plus 1 cycle for done.

## Configuration
- CRC_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0].
  - Increments at each done with crc_ok=0; saturates at 8'hFF.
  - Cleared only by rst_n.
  - frame_err aborts do not count.
- CRC_ERR_CNT_EN undefined: no err_cnt port and no counter logic; all other behaviour identical.

## Test plan
- Good frame: start + 48 contiguous bits of 48'h03010203_FAED -> done after the 48th bit; payload=32'h03010203, crc_rx=16'hFAED, crc_ok=1.
- Corrupted frame: same frame with bit 20 flipped -> done; crc_ok=0, crc_rx=16'hFAED; with CRC_ERR_CNT_EN, err_cnt 0->1.
- Gapped input: good frame with in_valid low on every other cycle -> identical results; done 1 cycle after the last valid bit; busy high throughout.
- Restart: start reasserted at bit 30 with a new good frame -> frame_err pulse, no done for the first frame, the second frame gives done with crc_ok=1.
- Back-to-back: two good frames, the second starting in the DONE cycle -> two done pulses exactly 48 cycles apart, both crc_ok=1.
- Reset mid-frame: rst_n low at bit 25 -> outputs return to reset values at once; a following good frame passes normally.
